// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register and write-back unit of the 5-stage MIPS
// pipeline. Captures the memory-stage result, aligns load data, drives the
// register file write port and counts retired instructions.
// Optional feature macro: WB_SUBWORD_LOAD_EN enables byte/halfword load
// alignment and extension; without it load data retires as the raw word.
module wb_stage #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_valid,
   input  logic              mem_reg_write,
   input  logic              mem_to_reg,
   input  logic [4:0]        mem_rd,
   input  logic [DATA_W-1:0] mem_alu_result,
   input  logic [DATA_W-1:0] mem_load_data,
   input  logic [1:0]        mem_load_size,
   input  logic              mem_load_unsigned,
   input  logic              stall,
   input  logic              flush,
   output logic              isWB,
   output logic [4:0]        write_reg,
   output logic [DATA_W-1:0] write_data,
   output logic              retire_pulse,
   output logic [CNT_W-1:0]  retire_count
);

   logic              wb_valid_r;
   logic              wb_reg_write_r;
   logic              wb_to_reg_r;
   logic [4:0]        wb_rd_r;
   logic [DATA_W-1:0] wb_alu_r;
   logic [DATA_W-1:0] wb_load_r;
   logic              wb_fresh_r;
   logic [CNT_W-1:0]  retire_count_r;
   logic [DATA_W-1:0] write_data_s;

`ifdef WB_SUBWORD_LOAD_EN
   logic [1:0]        wb_size_r;
   logic              wb_uns_r;

   // Select the addressed byte/halfword lane and sign- or zero-extend it.
   // Halfword lane uses address bit 1 only; misalignment is trapped upstream.
   function automatic logic [DATA_W-1:0] align_load(
      input logic [DATA_W-1:0] raw,
      input logic [1:0]        addr_lo,
      input logic [1:0]        size,
      input logic              uns
   );
      logic [7:0]        lane_b;
      logic [15:0]       lane_h;
      logic [DATA_W-1:0] res;
      lane_b = 8'h00;
      lane_h = 16'h0000;
      res    = raw;
      case (addr_lo)
         2'b00:   lane_b = raw[7:0];
         2'b01:   lane_b = raw[15:8];
         2'b10:   lane_b = raw[23:16];
         2'b11:   lane_b = raw[31:24];
         default: lane_b = raw[7:0];
      endcase
      if (addr_lo[1]) begin
         lane_h = raw[31:16];
      end else begin
         lane_h = raw[15:0];
      end
      case (size)
         2'b01:   res = {{(DATA_W-16){lane_h[15] & ~uns}}, lane_h};
         2'b10:   res = {{(DATA_W-8){lane_b[7] & ~uns}}, lane_b};
         default: res = raw;
      endcase
      return res;
   endfunction

   // Sub-word load controls follow the same capture/hold rules as the rest of the WB register.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_size_r <= 2'b00;
         wb_uns_r  <= 1'b0;
      end else if (flush || stall) begin
         wb_size_r <= wb_size_r;
         wb_uns_r  <= wb_uns_r;
      end else begin
         wb_size_r <= mem_load_size;
         wb_uns_r  <= mem_load_unsigned;
      end
   end
`else
   // Size/sign controls have no effect when sub-word alignment is not built.
   logic unused_load_ctrl_s;
   assign unused_load_ctrl_s = ^{mem_load_size, mem_load_unsigned};
`endif

   // WB pipeline register: reset clears, flush kills, stall holds, else capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_valid_r     <= 1'b0;
         wb_reg_write_r <= 1'b0;
         wb_to_reg_r    <= 1'b0;
         wb_rd_r        <= 5'd0;
         wb_alu_r       <= {DATA_W{1'b0}};
         wb_load_r      <= {DATA_W{1'b0}};
         wb_fresh_r     <= 1'b0;
      end else if (flush) begin
         wb_valid_r <= 1'b0;
         wb_fresh_r <= 1'b0;
      end else if (stall) begin
         wb_fresh_r <= 1'b0;
      end else begin
         wb_valid_r     <= mem_valid;
         wb_reg_write_r <= mem_reg_write;
         wb_to_reg_r    <= mem_to_reg;
         wb_rd_r        <= mem_rd;
         wb_alu_r       <= mem_alu_result;
         wb_load_r      <= mem_load_data;
         wb_fresh_r     <= mem_valid;
      end
   end

   // Retired-instruction counter; wraps freely, reset discards any pending retire.
   always_ff @(posedge clk) begin
      if (rst) begin
         retire_count_r <= {CNT_W{1'b0}};
      end else if (retire_pulse) begin
         retire_count_r <= retire_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         retire_count_r <= retire_count_r;
      end
   end

   // Choose the value to retire: ALU result or (aligned) load data.
   always_comb begin
      write_data_s = wb_alu_r;
      if (wb_to_reg_r) begin
`ifdef WB_SUBWORD_LOAD_EN
         write_data_s = align_load(wb_load_r, wb_alu_r[1:0], wb_size_r, wb_uns_r);
`else
         write_data_s = wb_load_r;
`endif
      end else begin
         write_data_s = wb_alu_r;
      end
   end

   // Outputs depend only on the WB register; $0 is never written.
   assign isWB         = wb_valid_r & wb_reg_write_r & (wb_rd_r != 5'd0);
   assign write_reg    = wb_rd_r;
   assign write_data   = write_data_s;
   assign retire_pulse = wb_valid_r & wb_fresh_r;
   assign retire_count = retire_count_r;

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage. Expected outputs are computed
// from the stimulus when it is driven, queued, and compared after the edge.
// A second instance with a 3-bit counter exercises counter wrap-around.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst, mem_valid, mem_reg_write, mem_to_reg;
   logic [4:0]  mem_rd;
   logic [31:0] mem_alu_result, mem_load_data;
   logic [1:0]  mem_load_size;
   logic        mem_load_unsigned, stall, flush;

   logic        isWB, retire_pulse;
   logic [4:0]  write_reg;
   logic [31:0] write_data, retire_count;

   logic        s_isWB, s_retire_pulse;
   logic [4:0]  s_write_reg;
   logic [31:0] s_write_data;
   logic [2:0]  s_retire_count;

   typedef struct packed {
      logic        is_wb;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        pulse;
      logic [31:0] cnt;
      logic [2:0]  cnt_s;
      logic        chk_data;
   } exp_t;

   exp_t q[$];

   int n_checks = 0;
   int n_fail   = 0;

   // bench-side model of the WB register contents
   logic        h_valid = 1'b0, h_rw = 1'b0, h_to_reg = 1'b0;
   logic [4:0]  h_rd = 5'd0;
   logic [31:0] h_alu = 32'd0, h_load = 32'd0;
   logic [1:0]  h_size = 2'b00;
   logic        h_uns = 1'b0;
   logic        prev_pulse = 1'b0;
   logic [31:0] cnt_m = 32'd0;

   always #5 clk = ~clk;

   wb_stage #(.DATA_W(32), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
      .mem_to_reg(mem_to_reg), .mem_rd(mem_rd), .mem_alu_result(mem_alu_result),
      .mem_load_data(mem_load_data), .mem_load_size(mem_load_size),
      .mem_load_unsigned(mem_load_unsigned), .stall(stall), .flush(flush),
      .isWB(isWB), .write_reg(write_reg), .write_data(write_data),
      .retire_pulse(retire_pulse), .retire_count(retire_count)
   );

   wb_stage #(.DATA_W(32), .CNT_W(3)) dut_small (
      .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
      .mem_to_reg(mem_to_reg), .mem_rd(mem_rd), .mem_alu_result(mem_alu_result),
      .mem_load_data(mem_load_data), .mem_load_size(mem_load_size),
      .mem_load_unsigned(mem_load_unsigned), .stall(stall), .flush(flush),
      .isWB(s_isWB), .write_reg(s_write_reg), .write_data(s_write_data),
      .retire_pulse(s_retire_pulse), .retire_count(s_retire_count)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Expected retire value written as shifts/masks of the raw word.
   function automatic logic [31:0] ref_data(input logic [31:0] alu, input logic [31:0] load,
                                             input logic to_reg, input logic [1:0] size,
                                             input logic uns);
      logic [31:0] sh;
      if (!to_reg) return alu;
`ifdef WB_SUBWORD_LOAD_EN
      if (size == 2'b10) begin
         sh = load >> {alu[1:0], 3'b000};
         return uns ? (sh & 32'h0000_00FF) : {{24{sh[7]}}, sh[7:0]};
      end
      if (size == 2'b01) begin
         sh = load >> {alu[1], 4'b0000};
         return uns ? (sh & 32'h0000_FFFF) : {{16{sh[15]}}, sh[15:0]};
      end
`endif
      return load;
   endfunction

   task automatic drive(input logic v, input logic rw, input logic tr, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] ld,
                        input logic [1:0] sz, input logic un);
      mem_valid = v; mem_reg_write = rw; mem_to_reg = tr; mem_rd = rd;
      mem_alu_result = alu; mem_load_data = ld; mem_load_size = sz; mem_load_unsigned = un;
   endtask

   task automatic drive_rand(input logic v);
      drive(v, 1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom,
            2'($urandom), 1'($urandom));
   endtask

   // One clock: compute expectation from driven inputs, push, clock, pop, compare.
   task automatic cycle(input logic c_stall, input logic c_flush, input logic c_rst, input string tag);
      exp_t e;
      stall = c_stall; flush = c_flush; rst = c_rst;
      if (c_rst) cnt_m = 32'd0;
      else if (prev_pulse) cnt_m = cnt_m + 32'd1;
      if (c_rst) begin
         h_valid = 1'b0; h_rw = 1'b0; h_to_reg = 1'b0; h_rd = 5'd0;
         h_alu = 32'd0; h_load = 32'd0; h_size = 2'b00; h_uns = 1'b0;
         e.pulse = 1'b0;
      end else if (c_flush) begin
         h_valid = 1'b0;
         e.pulse = 1'b0;
      end else if (c_stall) begin
         e.pulse = 1'b0;
      end else begin
         h_valid = mem_valid; h_rw = mem_reg_write; h_to_reg = mem_to_reg; h_rd = mem_rd;
         h_alu = mem_alu_result; h_load = mem_load_data; h_size = mem_load_size;
         h_uns = mem_load_unsigned;
         e.pulse = mem_valid;
      end
      e.is_wb    = h_valid & h_rw & (h_rd != 5'd0);
      e.rd       = h_rd;
      e.data     = ref_data(h_alu, h_load, h_to_reg, h_size, h_uns);
      e.cnt      = cnt_m;
      e.cnt_s    = cnt_m[2:0];
      e.chk_data = e.is_wb | c_rst;
      prev_pulse = e.pulse;
      q.push_back(e);
      @(posedge clk);
      #1;
      e = q.pop_front();
      check_eq($sformatf("%s.isWB", tag), {31'd0, isWB}, {31'd0, e.is_wb});
      check_eq($sformatf("%s.pulse", tag), {31'd0, retire_pulse}, {31'd0, e.pulse});
      check_eq($sformatf("%s.count", tag), retire_count, e.cnt);
      check_eq($sformatf("%s.count_small", tag), {29'd0, s_retire_count}, {29'd0, e.cnt_s});
      if (e.chk_data) begin
         check_eq($sformatf("%s.write_reg", tag), {27'd0, write_reg}, {27'd0, e.rd});
         check_eq($sformatf("%s.write_data", tag), write_data, e.data);
      end
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 2'b00, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, "reset0");
      cycle(1'b0, 1'b0, 1'b1, "reset1");

      // ALU writeback followed by a bubble so the count update is observed
      drive(1'b1, 1'b1, 1'b0, 5'd3, 32'h0000_0007, 32'h1234_5678, 2'b00, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, "alu_wb");
      drive(1'b0, 1'b1, 1'b0, 5'd9, 32'h0000_0009, 32'd0, 2'b00, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, "bubble");

      // write to $0 retires without asserting the write enable
      drive(1'b1, 1'b1, 1'b0, 5'd0, 32'hDEAD_BEEF, 32'd0, 2'b00, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, "r0_suppress");

      // load alignment cases
      drive(1'b1, 1'b1, 1'b1, 5'd5, 32'h1000_0002, 32'h80FF_7F01, 2'b10, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, "lb_lane2");
      drive(1'b1, 1'b1, 1'b1, 5'd6, 32'h1000_0002, 32'h80FF_7F01, 2'b01, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, "lhu_hi");
      drive(1'b1, 1'b1, 1'b1, 5'd7, 32'h1000_0003, 32'h80FF_7F01, 2'b01, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, "lh_hi_odd");
      drive(1'b1, 1'b1, 1'b1, 5'd8, 32'h1000_0000, 32'h80FF_7F81, 2'b10, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, "lbu_lane0");
      drive(1'b1, 1'b1, 1'b1, 5'd9, 32'h1000_0001, 32'h80FF_7F01, 2'b10, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, "lb_lane1");
      drive(1'b1, 1'b1, 1'b1, 5'd10, 32'h1000_0000, 32'h8000_8001, 2'b01, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, "lh_lo");
      drive(1'b1, 1'b1, 1'b1, 5'd11, 32'h1000_0002, 32'hCAFE_F00D, 2'b00, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, "lw");
      drive(1'b1, 1'b1, 1'b1, 5'd12, 32'h1000_0003, 32'h8765_4321, 2'b11, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, "l_reserved");

      // stall holds rd=4 / -90 for four cycles while inputs change
      drive(1'b1, 1'b1, 1'b0, 5'd4, 32'hFFFF_FFA6, 32'd0, 2'b00, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, "stall_issue");
      for (int i = 0; i < 4; i++) begin
         drive_rand(1'b1);
         cycle(1'b1, 1'b0, 1'b0, $sformatf("stall%0d", i));
      end

      // flush with stall, then flush alone: bubbles
      drive(1'b1, 1'b1, 1'b0, 5'd13, 32'h0000_1111, 32'd0, 2'b00, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, "flush_stall");
      drive(1'b1, 1'b1, 1'b0, 5'd14, 32'h0000_2222, 32'd0, 2'b00, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, "flush");

      // stream: five instructions with two bubbles
      for (int i = 0; i < 7; i++) begin
         drive_rand((i != 2) && (i != 4));
         cycle(1'b0, 1'b0, 1'b0, $sformatf("stream%0d", i));
      end

      // reset while a load is held by stall
      drive(1'b1, 1'b1, 1'b1, 5'd15, 32'h2000_0001, 32'hA5A5_5A5A, 2'b10, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, "held_load");
      drive_rand(1'b1);
      cycle(1'b1, 1'b0, 1'b0, "held_stall");
      cycle(1'b1, 1'b0, 1'b1, "rst_in_stall");
      drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 2'b00, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, "post_rst");

      // enough retirements to wrap the 3-bit counter
      for (int i = 0; i < 10; i++) begin
         drive_rand(1'b1);
         cycle(1'b0, 1'b0, 1'b0, $sformatf("wrap%0d", i));
      end
      drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 2'b00, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, "drain0");
      cycle(1'b0, 1'b0, 1'b0, "drain1");

      check_eq("queue_empty", q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
